// File: rtl/cf_fft_bitrev_reorder.sv
// rtl/cf_fft_bitrev_reorder.sv - ping-pong reorder buffer: natural-order writes, bit-reversed reads
module cf_fft_bitrev_reorder #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clock_c,
  input  logic          i1,
  input  logic          i2,
  input  logic          i3,
  input  logic [DW-1:0] i4,
  output logic          o1,
  output logic          o2,
  output logic [DW-1:0] o3,
  output logic          o4
);

  localparam int N = 1 << AW;

  logic [AW-1:0] cnt_q, cnt_d;
  logic          wb_q, wb_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic          start_dly_q, start_dly_d;
  logic [1:0]    frames_q, frames_d;
  logic          we;
  logic [AW:0]   wr_addr;

  logic [DW-1:0] mem [2*N];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int k = 0; k < AW; k++) r[k] = a[AW-1-k];
    return r;
  endfunction

  always_comb begin
    cnt_d       = cnt_q;
    wb_d        = wb_q;
    rd_addr_d   = rd_addr_q;
    start_dly_d = start_dly_q;
    frames_d    = frames_q;
    we          = 1'b0;
    wr_addr     = {wb_q, cnt_q};
    if (i2 && !i1) begin
      we = 1'b1;
      if (i3) begin
        // New frame lands in the other bank; the bank just filled becomes the read bank.
        wb_d        = ~wb_q;
        wr_addr     = {~wb_q, {AW{1'b0}}};
        cnt_d       = AW'(1);
        rd_addr_d   = {wb_q, bitrev({AW{1'b0}})};
        start_dly_d = 1'b1;
        frames_d    = (frames_q == 2'd2) ? 2'd2 : frames_q + 2'd1;
      end else begin
        cnt_d       = cnt_q + 1'b1;
        rd_addr_d   = {~wb_q, bitrev(cnt_q)};
        start_dly_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_c) begin
    if (i1) begin
      cnt_q       <= '0;
      wb_q        <= 1'b0;
      rd_addr_q   <= '0;
      start_dly_q <= 1'b0;
      frames_q    <= 2'd0;
    end else begin
      cnt_q       <= cnt_d;
      wb_q        <= wb_d;
      rd_addr_q   <= rd_addr_d;
      start_dly_q <= start_dly_d;
      frames_q    <= frames_d;
    end
  end

  always_ff @(posedge clock_c) begin
    if (we) mem[wr_addr] <= i4;
  end

  assign o3 = mem[rd_addr_q];
  assign o1 = start_dly_q;
  assign o2 = (rd_addr_q[AW-1:0] == '0);
  assign o4 = (frames_q == 2'd2);

endmodule

// File: tb/tb_cf_fft_bitrev_reorder.sv
// tb/tb_cf_fft_bitrev_reorder.sv - directed self-checking bench for cf_fft_bitrev_reorder
module tb_cf_fft_bitrev_reorder;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, en, st;
  logic [DW-1:0] din;
  logic          o1, o2, o4;
  logic [DW-1:0] o3;

  int checks   = 0;
  int failures = 0;
  int rev3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp_v [8];

  always #5 clk = ~clk;

  cf_fft_bitrev_reorder #(.DW(DW), .AW(AW)) dut (
    .clock_c(clk),
    .i1     (rst),
    .i2     (en),
    .i3     (st),
    .i4     (din),
    .o1     (o1),
    .o2     (o2),
    .o3     (o3),
    .o4     (o4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic s, input logic [DW-1:0] d);
    rst = r;
    en  = e;
    st  = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic set_seq(input int base);
    for (int i = 0; i < 8; i++) exp_v[i] = base + rev3[i];
  endtask

  task automatic check_out(input int i);
    check($sformatf("o3[%0d]", i), o3, exp_v[i]);
    check($sformatf("o1[%0d]", i), {31'd0, o1}, (i == 0) ? 1 : 0);
    check($sformatf("o2[%0d]", i), {31'd0, o2}, (i == 0) ? 1 : 0);
    check($sformatf("o4[%0d]", i), {31'd0, o4}, 1);
  endtask

  // One full frame; with gate set, each enabled cycle is followed by a
  // disabled one carrying a start pulse and junk data that must be ignored.
  task automatic send_frame(input int base, input bit chk, input bit gate);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, (i == 0), DW'(base + i));
      if (chk) check_out(i);
      if (gate) begin
        cyc(1'b0, 1'b0, 1'b1, DW'(32'hDEAD_0000 + i));
        if (chk) check_out(i);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; st = 1'b0; din = '0;

    cyc(1'b1, 1'b0, 1'b0, '0);
    check("rst_o1", {31'd0, o1}, 0);
    check("rst_o4", {31'd0, o4}, 0);
    check("rst_o2", {31'd0, o2}, 1);

    // Basic reorder and back-to-back continuity
    send_frame(0, 1'b0, 1'b0);
    set_seq(0);
    send_frame(8, 1'b1, 1'b0);
    set_seq(8);
    send_frame(16, 1'b1, 1'b0);

    // Enable gating
    cyc(1'b1, 1'b0, 1'b0, '0);
    send_frame(100, 1'b0, 1'b1);
    set_seq(100);
    send_frame(108, 1'b1, 1'b1);

    // Reset together with start, mid-frame
    cyc(1'b0, 1'b1, 1'b0, 99);
    cyc(1'b0, 1'b1, 1'b0, 98);
    cyc(1'b1, 1'b1, 1'b1, 77);
    check("midrst_o1", {31'd0, o1}, 0);
    check("midrst_o4", {31'd0, o4}, 0);
    check("midrst_o2", {31'd0, o2}, 1);
    send_frame(40, 1'b0, 1'b0);
    check("midrst_o4_one_start", {31'd0, o4}, 0);
    set_seq(40);
    send_frame(48, 1'b1, 1'b0);

    // Early start: short frame keeps stale words of its bank
    cyc(1'b1, 1'b0, 1'b0, '0);
    send_frame(0, 1'b0, 1'b0);
    set_seq(0);
    send_frame(8, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 20);
    check("early_o3_0", o3, 8);
    check("early_o1_0", {31'd0, o1}, 1);
    cyc(1'b0, 1'b1, 1'b0, 21);
    check("early_o3_1", o3, 12);
    cyc(1'b0, 1'b1, 1'b0, 22);
    check("early_o3_2", o3, 10);
    exp_v = '{20, 4, 22, 6, 21, 5, 3, 7};
    send_frame(30, 1'b1, 1'b0);

    // Counter wrap: 16 samples, single start
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 0);
    for (int k = 1; k < 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0, DW'(k));
      check($sformatf("wrap_o1[%0d]", k), {31'd0, o1}, 0);
    end
    set_seq(8);
    send_frame(60, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
